// File: rtl/fp_pkg.sv
// Shared float32 / int32 constants and enums for the FP conversion blocks.
package fp_pkg;
  localparam int FP32_EXP_W   = 8;
  localparam int FP32_MANT_W  = 23;
  localparam int FP32_BIAS    = 127;
  localparam int FP32_EXP_MAX = 255;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_NEG, ST_DONE} state_t;

  typedef enum logic [2:0] {
    CLS_NAN, CLS_INF, CLS_ZERO, CLS_SAT, CLS_NEGMIN, CLS_NORMAL
  } cls_t;
endpackage

// File: rtl/fp32_classify.sv
// Combinational float32 decode: class, unbiased exponent, alignment shift count/direction.
module fp32_classify
  import fp_pkg::*;
(
  input  logic              [31:0] f,
  output cls_t                     cls,
  output logic signed       [8:0]  e,
  output logic              [4:0]  cnt,
  output logic                     dir_left
);
  logic [FP32_EXP_W-1:0]  ex;
  logic [FP32_MANT_W-1:0] mant;

  assign ex   = f[30:23];
  assign mant = f[22:0];
  assign e    = $signed({1'b0, ex}) - 9'(FP32_BIAS);

  // Priority classification; shift count only meaningful for CLS_NORMAL.
  // |e-23| = |ex-150|, and 150 mod 32 = 22, so 5-bit arithmetic on ex[4:0] is exact for 0..23.
  always_comb begin
    cls      = CLS_NORMAL;
    cnt      = 5'd0;
    dir_left = 1'b0;
    if (ex == 8'(FP32_EXP_MAX) && mant != '0)  cls = CLS_NAN;
    else if (ex == 8'(FP32_EXP_MAX))           cls = CLS_INF;
    else if (ex == '0 || e < 9'sd0)            cls = CLS_ZERO;
    else if (f == 32'hCF00_0000)               cls = CLS_NEGMIN;
    else if (e >= 9'sd31)                      cls = CLS_SAT;
    else if (e > 9'sd23) begin
      dir_left = 1'b1;
      cnt      = ex[4:0] - 5'd22;
    end else begin
      cnt      = 5'd22 - ex[4:0];
    end
  end
endmodule

// File: rtl/fp32_to_int32_iter.sv
// Iterative float32 -> int32 converter (truncate toward zero, saturating),
// using a STEP-bits-per-cycle shift register instead of a barrel shifter.
module fp32_to_int32_iter
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_ovf,
  output logic        out_nan
);
  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t             state, state_nx;
  cls_t               c_cls;
  logic signed [8:0]  c_e;
  logic [4:0]         c_cnt;
  logic               c_left;

  logic               sgn, left;
  logic [31:0]        mag;
  logic [4:0]         cnt;
  logic [2:0]         amt;

  fp32_classify u_cls (
    .f        (in_float),
    .cls      (c_cls),
    .e        (c_e),
    .cnt      (c_cnt),
    .dir_left (c_left)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign amt       = (cnt < STEP5) ? cnt[2:0] : STEP5[2:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state: specials finish in one cycle, e==23 skips alignment
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) begin
                  if (c_cls != CLS_NORMAL) state_nx = ST_DONE;
                  else if (c_e == 9'sd23)  state_nx = ST_NEG;
                  else                     state_nx = ST_SHIFT;
                end
      ST_SHIFT: if (cnt == {2'b00, amt}) state_nx = ST_NEG;
      ST_NEG:   state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Datapath: latch operand, align by shifting, negate, hold result through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn     <= 1'b0;
      left    <= 1'b0;
      mag     <= '0;
      cnt     <= '0;
      out_int <= '0;
      out_ovf <= 1'b0;
      out_nan <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          sgn  <= in_float[31];
          left <= c_left;
          cnt  <= c_cnt;
          mag  <= {8'b0, 1'b1, in_float[22:0]};
          case (c_cls)
            CLS_NAN:    begin out_int <= '0;        out_ovf <= 1'b0; out_nan <= 1'b1; end
            CLS_INF,
            CLS_SAT:    begin out_int <= in_float[31] ? INT32_MIN : INT32_MAX;
                              out_ovf <= 1'b1; out_nan <= 1'b0; end
            CLS_ZERO:   begin out_int <= '0;        out_ovf <= 1'b0; out_nan <= 1'b0; end
            CLS_NEGMIN: begin out_int <= INT32_MIN; out_ovf <= 1'b0; out_nan <= 1'b0; end
            default: ;
          endcase
        end
        ST_SHIFT: begin
          mag <= left ? (mag << amt) : (mag >> amt);
          cnt <= cnt - {2'b00, amt};
        end
        ST_NEG: begin
          out_int <= sgn ? -mag : mag;
          out_ovf <= 1'b0;
          out_nan <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_to_int32_iter.sv
// Bench: three instances (STEP = 1, 2, 4) driven in lockstep, directed table,
// hand-written hold/reset sequences, random sweep and int->float round trip.
module tb_fp32_to_int32_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, out_ready;
  logic [31:0]       in_float;
  logic [2:0]        in_ready, out_valid, out_ovf, out_nan;
  logic [2:0][31:0]  out_int;

  int steps [3] = '{1, 2, 4};
  int n_cmp = 0;
  int n_err = 0;

  fp32_to_int32_iter #(.STEP(1)) u_s1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_float(in_float), .out_valid(out_valid[0]), .out_ready(out_ready), .out_int(out_int[0]),
    .out_ovf(out_ovf[0]), .out_nan(out_nan[0]));
  fp32_to_int32_iter #(.STEP(2)) u_s2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_float(in_float), .out_valid(out_valid[1]), .out_ready(out_ready), .out_int(out_int[1]),
    .out_ovf(out_ovf[1]), .out_nan(out_nan[1]));
  fp32_to_int32_iter #(.STEP(4)) u_s4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_float(in_float), .out_valid(out_valid[2]), .out_ready(out_ready), .out_int(out_int[2]),
    .out_ovf(out_ovf[2]), .out_nan(out_nan[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: value = (1.mant) * 2^(e-23) truncated toward zero, then range-checked.
  // special=1 means the block answers without alignment (one-cycle class).
  function automatic void model(input logic [31:0] f, output logic [31:0] r, output logic ovf,
                                output logic nan, output int cnt, output bit special);
    int ex, e;
    longint m, v;
    ex = int'(f[30:23]);
    e  = ex - 127;
    r = 0; ovf = 0; nan = 0; cnt = 0; special = 1;
    if (ex == 255) begin
      if (f[22:0] != 0) nan = 1;
      else begin ovf = 1; r = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; end
    end else if (ex == 0 || e < 0) begin
      r = 0;
    end else if (e >= 32) begin
      ovf = 1; r = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      m = 64'(f[22:0]) + 64'h80_0000;
      v = (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
      if (f[31]) v = -v;
      if (v > 64'sd2147483647)       begin ovf = 1; r = 32'h7FFF_FFFF; end
      else if (v < -64'sd2147483648) begin ovf = 1; r = 32'h8000_0000; end
      else r = v[31:0];
      special = (e >= 31);
      cnt = (e >= 23) ? e - 23 : 23 - e;
    end
  endfunction

  // Exact int -> float32 for |x| < 2^24 (stand-in for the upstream int2float32 stage)
  function automatic logic [31:0] int2f(input int x);
    int a, p;
    logic [31:0] sh;
    if (x == 0) return 32'h0;
    a = (x < 0) ? -x : x;
    p = 0;
    for (int i = 0; i < 24; i++) if (a[i]) p = i;
    sh = 32'(a) << (23 - p);
    return {(x < 0), 8'(127 + p), sh[22:0]};
  endfunction

  // One transaction on all three instances; checks result, flags and out_valid latency.
  task automatic xact(input string nm, input logic [31:0] f, input logic [31:0] er,
                      input logic eo, input logic en, input int cnt, input bit special);
    int lat [3];
    int cyc;
    lat = '{-1, -1, -1};
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 32'h7);
    in_valid = 1'b1;
    in_float = f;
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) if (out_valid[k] && lat[k] < 0) lat[k] = cyc;
      if (out_valid == 3'b111 || cyc >= 40) break;
      @(posedge clk);
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s s%0d int", nm, steps[k]), out_int[k], er);
      chk($sformatf("%s s%0d flags", nm, steps[k]), {30'b0, out_ovf[k], out_nan[k]}, {30'b0, eo, en});
      chk($sformatf("%s s%0d latency", nm, steps[k]), 32'(lat[k]),
          special ? 32'd1 : 32'((cnt + steps[k] - 1) / steps[k] + 2));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " back to idle"}, {29'b0, out_valid}, 32'h0);
  endtask

  task automatic xact_model(input string nm, input logic [31:0] f);
    logic [31:0] r; logic o, n; int c; bit s;
    model(f, r, o, n, c, s);
    xact(nm, f, r, o, n, c, s);
  endtask

  typedef struct {
    logic [31:0] f;
    logic [31:0] r;
    logic        ovf;
    logic        nan;
    int          cnt;   // -1: one-cycle class
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] r0;
    logic        seen;
    int          x;

    vecs = '{
      '{32'h4120_0000, 32'h0000_000A, 0, 0, 20},
      '{32'hC2F6_E979, 32'hFFFF_FF85, 0, 0, 17},
      '{32'h3F7F_FFFF, 32'h0000_0000, 0, 0, -1},
      '{32'h0000_0001, 32'h0000_0000, 0, 0, -1},
      '{32'h4F00_0000, 32'h7FFF_FFFF, 1, 0, -1},
      '{32'hCF00_0000, 32'h8000_0000, 0, 0, -1},
      '{32'hFF80_0000, 32'h8000_0000, 1, 0, -1},
      '{32'h7FC0_0000, 32'h0000_0000, 0, 1, -1},
      '{32'h4B00_0001, 32'h0080_0001, 0, 0, 0},
      '{32'h3F80_0000, 32'h0000_0001, 0, 0, 23},
      '{32'h4EFF_FFFF, 32'h7FFF_FF80, 0, 0, 7},
      '{32'hCEFF_FFFF, 32'h8000_0080, 0, 0, 7},
      '{32'hCF00_0001, 32'h8000_0000, 1, 0, -1},
      '{32'h8000_0000, 32'h0000_0000, 0, 0, -1},
      '{32'hBF80_0000, 32'hFFFF_FFFF, 0, 0, 23},
      '{32'h7F80_0000, 32'h7FFF_FFFF, 1, 0, -1}
    };

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_float = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {29'b0, out_valid}, 32'h0);
    chk("reset flags", {26'b0, out_ovf, out_nan}, 32'h0);
    for (int k = 0; k < 3; k++) chk($sformatf("reset s%0d out_int", steps[k]), out_int[k], 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", {29'b0, in_ready}, 32'h7);

    for (int i = 0; i < 16; i++)
      xact($sformatf("vec%0d", i), vecs[i].f, vecs[i].r, vecs[i].ovf, vecs[i].nan,
           (vecs[i].cnt < 0) ? 0 : vecs[i].cnt, vecs[i].cnt < 0);

    // Hold result with out_ready low; in_valid pulses must be ignored
    @(negedge clk);
    in_valid = 1'b1; in_float = 32'h4B00_0001;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", c), {29'b0, out_valid}, 32'h7);
      chk($sformatf("hold%0d in_ready", c), {29'b0, in_ready}, 32'h0);
      for (int k = 0; k < 3; k++) chk($sformatf("hold%0d s%0d out_int", c, steps[k]), out_int[k], 32'h0080_0001);
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_float = 32'h3F80_0000;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("hold release idle", {26'b0, in_ready, out_valid}, {26'b0, 3'b111, 3'b000});

    // Reset during SHIFT discards the in-flight result
    @(negedge clk);
    in_valid = 1'b1; in_float = 32'h3F80_0000;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre-abort busy", {29'b0, in_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", {29'b0, in_ready}, 32'h7);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid != 0) seen = 1'b1;
    end
    chk("abort no out_valid", {31'b0, seen}, 32'h0);
    xact("after abort 3.0", 32'h4040_0000, 32'h3, 0, 0, 22, 0);

    // Random sweep: fully random words and exponent-focused words
    for (int i = 0; i < 30; i++) xact_model($sformatf("rnd%0d", i), $urandom);
    for (int i = 0; i < 30; i++) begin
      r0 = $urandom;
      r0[30:23] = 8'($urandom_range(120, 162));
      xact_model($sformatf("rexp%0d", i), r0);
    end

    // Round trip through an exact int -> float conversion
    for (int i = 0; i < 30; i++) begin
      x = int'($urandom_range(0, 24'hFF_FFFF));
      if ($urandom_range(0, 1) == 1) x = -x;
      xact_model($sformatf("trip%0d x=%0d", i, x), int2f(x));
      chk($sformatf("trip%0d value", i), out_int[0], 32'(x));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
